// File: rtl/mdu_sequencer_pkg.sv
// Shared types and helpers for the RV32M multiply/divide sequencer.
package mdu_sequencer_pkg;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_BUSY = 2'd1,
        MDU_DONE = 2'd2
    } mduState_e;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    // Latched operation descriptor: which result to select and whether to negate it
    typedef struct packed {
        logic [2:0] funct3;
        logic       negRes;
    } mduOp_t;

    function automatic logic isSignedA(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    function automatic logic isSignedB(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/mdu_sequencer_step.sv
// One combinational iteration: shift-add multiply or restoring shift-subtract divide.
module mdu_sequencer_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             isDiv,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] opnd,
    output logic [WIDTH-1:0] hiNext,
    output logic [WIDTH-1:0] loNext
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : (WIDTH+1)'(0));
        shifted = {hi, lo[WIDTH-1]};
        diff    = shifted - {1'b0, opnd};
        hiNext  = '0;
        loNext  = '0;
        if (isDiv) begin
            // Borrow out of the (W+1)-bit trial subtract means the divisor did not fit
            if (!diff[WIDTH]) begin
                hiNext = diff[WIDTH-1:0];
                loNext = {lo[WIDTH-2:0], 1'b1};
            end else begin
                hiNext = shifted[WIDTH-1:0];
                loNext = {lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            hiNext = sum[WIDTH:1];
            loNext = {sum[0], lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mdu_sequencer.sv
// Multi-cycle RV32M multiply/divide unit with pipeline stall handshake.
module mdu_sequencer
    import mdu_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [2:0]       i_funct3,
    input  logic [WIDTH-1:0] i_rs1,
    input  logic [WIDTH-1:0] i_rs2,
    input  logic             i_flush,
    output logic             o_stall,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_result
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    mduState_e        stateQ, stateD;
    logic [CNT_W-1:0] countQ, countD;
    logic [WIDTH-1:0] hiQ, hiD, loQ, loD, opndQ, opndD;
    logic [WIDTH-1:0] resultQ, resultD;
    logic             validQ, validD;
    mduOp_t           opQ, opD;
    logic             stallC;

    logic             sA, sB, launchDiv, divZero, sgnOvf;
    logic [WIDTH-1:0] magA, magB, specialRes;
    logic [WIDTH-1:0] stepHi, stepLo, fixedRes;
    logic [2*WIDTH-1:0] prodMag, prodFix;

    mdu_sequencer_step #(.WIDTH(WIDTH)) uStep (
        .isDiv  (opQ.funct3[2]),
        .hi     (hiQ),
        .lo     (loQ),
        .opnd   (opndQ),
        .hiNext (stepHi),
        .loNext (stepLo)
    );

    // Launch-time decode: operand magnitudes, signs and early-out results
    always_comb begin
        sA         = isSignedA(i_funct3) & i_rs1[WIDTH-1];
        sB         = isSignedB(i_funct3) & i_rs2[WIDTH-1];
        magA       = sA ? WIDTH'(-i_rs1) : i_rs1;
        magB       = sB ? WIDTH'(-i_rs2) : i_rs2;
        launchDiv  = i_funct3[2];
        divZero    = launchDiv && (i_rs2 == '0);
        sgnOvf     = launchDiv && !i_funct3[0] && (i_rs1 == MIN_NEG) && (i_rs2 == '1);
        specialRes = '0;
        if (divZero) begin
            specialRes = i_funct3[1] ? i_rs1 : '1;
        end else if (sgnOvf) begin
            specialRes = i_funct3[1] ? '0 : MIN_NEG;
        end
    end

    // Sign fix-up and result select on the final iteration
    always_comb begin
        prodMag  = {stepHi, stepLo};
        prodFix  = opQ.negRes ? (2*WIDTH)'(-prodMag) : prodMag;
        fixedRes = '0;
        case (opQ.funct3)
            F3_MUL:                        fixedRes = prodFix[WIDTH-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU:  fixedRes = prodFix[2*WIDTH-1:WIDTH];
            F3_DIV, F3_DIVU:               fixedRes = opQ.negRes ? WIDTH'(-stepLo) : stepLo;
            F3_REM, F3_REMU:               fixedRes = opQ.negRes ? WIDTH'(-stepHi) : stepHi;
            default:                       fixedRes = '0;
        endcase
    end

    // Next-state and datapath control
    always_comb begin
        stateD  = stateQ;
        countD  = countQ;
        hiD     = hiQ;
        loD     = loQ;
        opndD   = opndQ;
        opD     = opQ;
        resultD = resultQ;
        validD  = 1'b0;
        stallC  = 1'b0;
        case (stateQ)
            MDU_IDLE: begin
                if (i_start && !i_flush) begin
                    stallC     = 1'b1;
                    opD.funct3 = i_funct3;
                    opD.negRes = (launchDiv && i_funct3[1]) ? sA : (sA ^ sB);
                    hiD        = '0;
                    loD        = launchDiv ? magA : magB;
                    opndD      = launchDiv ? magB : magA;
                    if (divZero || sgnOvf) begin
                        stateD  = MDU_DONE;
                        resultD = specialRes;
                        validD  = 1'b1;
                        countD  = '0;
                    end else begin
                        stateD = MDU_BUSY;
                        countD = CNT_W'(WIDTH);
                    end
                end
            end
            MDU_BUSY: begin
                stallC = 1'b1;
                if (i_flush) begin
                    stateD = MDU_IDLE;
                    countD = '0;
                end else begin
                    hiD    = stepHi;
                    loD    = stepLo;
                    countD = countQ - CNT_W'(1);
                    if (countQ == CNT_W'(1)) begin
                        stateD  = MDU_DONE;
                        resultD = fixedRes;
                        validD  = 1'b1;
                    end
                end
            end
            MDU_DONE: begin
                // Pipeline advances on this edge; a still-high i_start belongs to this op
                stateD = MDU_IDLE;
            end
            default: begin
                stateD = MDU_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            stateQ  <= MDU_IDLE;
            countQ  <= '0;
            hiQ     <= '0;
            loQ     <= '0;
            opndQ   <= '0;
            opQ     <= '0;
            resultQ <= '0;
            validQ  <= 1'b0;
        end else begin
            stateQ  <= stateD;
            countQ  <= countD;
            hiQ     <= hiD;
            loQ     <= loD;
            opndQ   <= opndD;
            opQ     <= opD;
            resultQ <= resultD;
            validQ  <= validD;
        end
    end

    assign o_stall  = stallC & ~i_rst;
    assign o_valid  = validQ & ~i_flush;
    assign o_result = resultQ;

endmodule
